// File: rtl/sntc_ldpc_iter_ctrl.sv
// sntc_ldpc_iter_ctrl
// Iteration/termination controller for the LDPC decoder core. Accepts a
// frame, pulses load/iterate to the core, tracks the best syndrome weight
// and a stall count, and terminates on convergence, iteration budget or
// stall. A status record is held until the consumer takes it, and
// saturating pass/fail frame counters are kept.
module sntc_ldpc_iter_ctrl #(
    parameter int SW_W    = 32,
    parameter int ITER_W  = 8,
    parameter int STALL_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ITER_W-1:0]  max_iter,
    input  logic [STALL_W-1:0] stall_limit,
    output logic               load_frame,
    output logic               start_iter,
    input  logic               iter_done,
    input  logic [SW_W-1:0]    syn_weight,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_status,
    output logic [ITER_W-1:0]  out_iters,
    output logic [SW_W-1:0]    out_best_wt,
    output logic [CNT_W-1:0]   frames_ok,
    output logic [CNT_W-1:0]   frames_fail
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_CONV  = 2'b01;
    localparam logic [1:0] ST_MAX   = 2'b10;
    localparam logic [1:0] ST_STALL = 2'b11;

    localparam logic [SW_W-1:0]    SW_ONES    = {SW_W{1'b1}};
    localparam logic [SW_W-1:0]    SW_ZERO    = {SW_W{1'b0}};
    localparam logic [STALL_W-1:0] STALL_ONES = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ZERO = {STALL_W{1'b0}};
    localparam logic [STALL_W-1:0] STALL_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]  ITER_ZERO  = {ITER_W{1'b0}};
    localparam logic [ITER_W:0]    N_ONE      = {{ITER_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONES   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]         r_state;
    logic [ITER_W-1:0]  r_max_iter;
    logic [STALL_W-1:0] r_stall_limit;
    logic [ITER_W-1:0]  r_iter_cnt;
    logic [SW_W-1:0]    r_best;
    logic [STALL_W-1:0] r_stall;
    logic               r_in_ready, r_load, r_start, r_out_valid;
    logic [1:0]         r_status;
    logic [ITER_W-1:0]  r_iters;
    logic [SW_W-1:0]    r_best_out;
    logic [CNT_W-1:0]   r_ok, r_fail;

    logic [2:0]         w_state_nxt;
    logic [ITER_W:0]    w_n, w_max_eff;
    logic               w_better;
    logic [SW_W-1:0]    w_best_nxt;
    logic [STALL_W-1:0] w_stall_nxt;
    logic [1:0]         w_term;
    logic               w_accept, w_wait_done;

    assign w_accept    = (r_state == S_IDLE) && r_in_ready && in_valid;
    assign w_wait_done = (r_state == S_WAIT) && iter_done;

    // Per-iteration progress tracking and termination decision
    always_comb begin
        w_n = {1'b0, r_iter_cnt} + N_ONE;
        if (r_max_iter == ITER_ZERO) begin
            w_max_eff = N_ONE;
        end else begin
            w_max_eff = {1'b0, r_max_iter};
        end
        w_better = (syn_weight < r_best);
        if (w_better) begin
            w_best_nxt  = syn_weight;
            w_stall_nxt = STALL_ZERO;
        end else begin
            w_best_nxt = r_best;
            if (r_stall == STALL_ONES) begin
                w_stall_nxt = r_stall;
            end else begin
                w_stall_nxt = r_stall + STALL_ONE;
            end
        end
        if (syn_weight == SW_ZERO) begin
            w_term = ST_CONV;
        end else if (w_n >= w_max_eff) begin
            w_term = ST_MAX;
        end else if ((r_stall_limit != STALL_ZERO) && (w_stall_nxt >= r_stall_limit)) begin
            w_term = ST_STALL;
        end else begin
            w_term = ST_NONE;
        end
    end

    // Next-state selection for the frame sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_LOAD;
                else          w_state_nxt = S_IDLE;
            end
            S_LOAD: w_state_nxt = S_ITER;
            S_ITER: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!iter_done)            w_state_nxt = S_WAIT;
                else if (w_term == ST_NONE) w_state_nxt = S_ITER;
                else                       w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and handshake/pulse outputs decoded from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_load      <= 1'b0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_load      <= 1'b0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_load      <= (w_state_nxt == S_LOAD);
            r_start     <= (w_state_nxt == S_ITER);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Frame context: limits captured at accept, progress updated per iteration
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_max_iter    <= ITER_ZERO;
            r_stall_limit <= STALL_ZERO;
            r_iter_cnt    <= ITER_ZERO;
            r_best        <= SW_ONES;
            r_stall       <= STALL_ZERO;
        end else if (clr) begin
            r_max_iter    <= ITER_ZERO;
            r_stall_limit <= STALL_ZERO;
            r_iter_cnt    <= ITER_ZERO;
            r_best        <= SW_ONES;
            r_stall       <= STALL_ZERO;
        end else if (w_accept) begin
            r_max_iter    <= max_iter;
            r_stall_limit <= stall_limit;
            r_iter_cnt    <= ITER_ZERO;
            r_best        <= SW_ONES;
            r_stall       <= STALL_ZERO;
        end else if (w_wait_done) begin
            r_iter_cnt    <= w_n[ITER_W-1:0];
            r_best        <= w_best_nxt;
            r_stall       <= w_stall_nxt;
        end
    end

    // Status record captured on the terminating iteration, held through DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_status   <= ST_NONE;
            r_iters    <= ITER_ZERO;
            r_best_out <= SW_ZERO;
        end else if (clr) begin
            r_status   <= ST_NONE;
            r_iters    <= ITER_ZERO;
            r_best_out <= SW_ZERO;
        end else if (w_wait_done && (w_term != ST_NONE)) begin
            r_status   <= w_term;
            r_iters    <= w_n[ITER_W-1:0];
            r_best_out <= w_best_nxt;
        end
    end

    // Saturating frame counters, bumped once as DONE is entered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ok   <= CNT_ZERO;
            r_fail <= CNT_ZERO;
        end else if (clr) begin
            r_ok   <= CNT_ZERO;
            r_fail <= CNT_ZERO;
        end else if (w_wait_done && (w_term == ST_CONV)) begin
            if (r_ok != CNT_ONES) r_ok <= r_ok + CNT_ONE;
        end else if (w_wait_done && (w_term != ST_NONE)) begin
            if (r_fail != CNT_ONES) r_fail <= r_fail + CNT_ONE;
        end
    end

    assign in_ready    = r_in_ready;
    assign load_frame  = r_load;
    assign start_iter  = r_start;
    assign out_valid   = r_out_valid;
    assign out_status  = r_status;
    assign out_iters   = r_iters;
    assign out_best_wt = r_best_out;
    assign frames_ok   = r_ok;
    assign frames_fail = r_fail;

endmodule

// File: tb/tb_sntc_ldpc_iter_ctrl.sv
// Testbench for sntc_ldpc_iter_ctrl: directed table of frames, a clear/abort
// sequence, and randomized frames checked against a behavioural model.
module tb_sntc_ldpc_iter_ctrl;

    localparam int SW_W    = 32;
    localparam int ITER_W  = 8;
    localparam int STALL_W = 4;
    localparam int CNT_W   = 32;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [ITER_W-1:0]  max_iter = '0;
    logic [STALL_W-1:0] stall_limit = '0;
    logic               load_frame, start_iter;
    logic               iter_done = 1'b0;
    logic [SW_W-1:0]    syn_weight = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [1:0]         out_status;
    logic [ITER_W-1:0]  out_iters;
    logic [SW_W-1:0]    out_best_wt;
    logic [CNT_W-1:0]   frames_ok, frames_fail;

    int checks = 0;
    int errors = 0;
    int exp_ok = 0;
    int exp_fail = 0;
    int wts[32];

    typedef struct {
        int w[8];
        int mi;
        int sl;
        int hold;
        int st;
        int it;
        int bw;
    } vec_t;
    vec_t vecs[7];

    sntc_ldpc_iter_ctrl #(.SW_W(SW_W), .ITER_W(ITER_W), .STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .max_iter(max_iter), .stall_limit(stall_limit),
        .load_frame(load_frame), .start_iter(start_iter),
        .iter_done(iter_done), .syn_weight(syn_weight),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_status(out_status), .out_iters(out_iters), .out_best_wt(out_best_wt),
        .frames_ok(frames_ok), .frames_fail(frames_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk the weight list applying best/stall/termination rules
    function automatic void model(input int mi, input int sl, output int st,
                                  output int it, output longint bw);
        longint best = 64'hFFFF_FFFF;
        int stall = 0;
        int lim = (mi == 0) ? 1 : mi;
        st = 0; it = 0; bw = best;
        for (int i = 0; i < 32 && st == 0; i++) begin
            if (wts[i] < best) begin best = wts[i]; stall = 0; end
            else stall++;
            it = i + 1;
            bw = best;
            if (wts[i] == 0)                  st = 1;
            else if (it >= lim)               st = 2;
            else if (sl != 0 && stall >= sl)  st = 3;
        end
    endfunction

    // Drive one frame through the controller, acting as core and consumer
    task automatic run_frame(input int mi, input int sl, input int hold, input int abort_at,
                             input int est, input int eit, input longint ebw);
        int k;
        int budget;
        budget = 0;
        while (!in_ready && budget < 20) begin tick(); budget++; end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; max_iter = mi[ITER_W-1:0]; stall_limit = sl[STALL_W-1:0];
        tick();
        in_valid = 1'b0; max_iter = ITER_W'($urandom); stall_limit = STALL_W'($urandom);
        chk("load_pulse", load_frame, 1);
        chk("start_not_with_load", start_iter, 0);
        chk("in_ready_busy", in_ready, 0);
        tick();
        chk("start_latency", start_iter, 1);
        chk("load_one_cycle", load_frame, 0);
        k = 0;
        while (start_iter && k < 32) begin
            iter_done = 1'($urandom_range(0, 1)); syn_weight = '0;
            tick();
            iter_done = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            if (k == abort_at) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                exp_ok = 0; exp_fail = 0;
                chk("clr_out_valid", out_valid, 0);
                chk("clr_status", out_status, 0);
                chk("clr_frames_ok", frames_ok, 0);
                chk("clr_frames_fail", frames_fail, 0);
                chk("clr_in_ready_low", in_ready, 0);
                tick();
                chk("clr_in_ready_rise", in_ready, 1);
                chk("clr_no_valid", out_valid, 0);
                return;
            end
            iter_done = 1'b1; syn_weight = wts[k]; k++;
            tick();
            iter_done = 1'b0; syn_weight = $urandom;
        end
        chk("done_reached", out_valid, 1);
        if (est == 1) exp_ok++; else exp_fail++;
        chk("status", out_status, est);
        chk("iters", out_iters, eit);
        chk("best_wt", out_best_wt, ebw);
        chk("frames_ok", frames_ok, exp_ok);
        chk("frames_fail", frames_fail, exp_fail);
        repeat (hold) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_status", out_status, est);
            chk("hold_iters", out_iters, eit);
            chk("hold_best", out_best_wt, ebw);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_frames_ok", frames_ok, exp_ok);
            chk("hold_frames_fail", frames_fail, exp_fail);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("release_valid_drop", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_no_accept", load_frame, 0);
    endtask

    initial begin
        int st, it;
        longint bw;

        vecs[0] = '{w: '{9, 4, 0, 0, 0, 0, 0, 0}, mi: 10, sl: 0, hold: 1, st: 1, it: 3, bw: 0};
        vecs[1] = '{w: '{5, 4, 3, 2, 1, 1, 1, 1}, mi: 4,  sl: 0, hold: 5, st: 2, it: 4, bw: 2};
        vecs[2] = '{w: '{6, 6, 7, 6, 5, 5, 5, 5}, mi: 20, sl: 3, hold: 0, st: 3, it: 4, bw: 6};
        vecs[3] = '{w: '{1, 1, 1, 1, 1, 1, 1, 1}, mi: 0,  sl: 0, hold: 2, st: 2, it: 1, bw: 1};
        vecs[4] = '{w: '{3, 3, 3, 3, 3, 3, 3, 3}, mi: 9,  sl: 1, hold: 0, st: 3, it: 2, bw: 3};
        vecs[5] = '{w: '{5, 0, 9, 9, 9, 9, 9, 9}, mi: 2,  sl: 0, hold: 1, st: 1, it: 2, bw: 0};
        vecs[6] = '{w: '{4, 4, 4, 4, 4, 4, 4, 4}, mi: 2,  sl: 1, hold: 0, st: 2, it: 2, bw: 4};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_load", load_frame, 0);
        chk("rst_start", start_iter, 0);
        chk("rst_frames_ok", frames_ok, 0);
        chk("rst_frames_fail", frames_fail, 0);
        rstn = 1'b1;
        tick();
        chk("rst_in_ready_rise", in_ready, 1);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 32; j++) wts[j] = vecs[i].w[(j < 8) ? j : 7];
            run_frame(vecs[i].mi, vecs[i].sl, vecs[i].hold, -1, vecs[i].st, vecs[i].it, vecs[i].bw);
        end

        // Abort during WAIT after two iterations, then a normal frame
        for (int j = 0; j < 32; j++) wts[j] = 40 - j;
        run_frame(10, 0, 0, 2, 0, 0, 0);
        for (int j = 0; j < 32; j++) wts[j] = (j == 0) ? 9 : (j == 1) ? 4 : 0;
        run_frame(10, 0, 0, -1, 1, 3, 0);

        // Randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            int mi, sl;
            mi = $urandom_range(0, 6);
            sl = $urandom_range(0, 3);
            for (int j = 0; j < 32; j++) wts[j] = $urandom_range(0, 7);
            model(mi, sl, st, it, bw);
            run_frame(mi, sl, $urandom_range(0, 3), -1, st, it, bw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
